// File: rtl/iiitb_freqmeas.sv
// Clock-period and duty-cycle monitor for the divider output: measures the high
// and low time of each complete clk_div_i period in wb_clk_i cycles.
module iiitb_freqmeas #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             en_i,
    input  logic             clk_div_i,
    output logic [WIDTH-1:0] high_o,
    output logic [WIDTH-1:0] low_o,
    output logic [WIDTH:0]   period_o,
    output logic             valid_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] meas_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] high_cnt;
    logic [WIDTH-1:0] low_cnt;

    // The synchronizer runs regardless of en_i so edges are valid as soon as enable rises.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_div_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            high_cnt   <= '0;
            low_cnt    <= '0;
            high_o     <= '0;
            low_o      <= '0;
            period_o   <= '0;
            valid_o    <= 1'b0;
            stall_o    <= 1'b0;
            meas_cnt_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (!en_i) begin
                state    <= IDLE;
                high_cnt <= '0;
                low_cnt  <= '0;
                stall_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        high_cnt <= '0;
                        low_cnt  <= '0;
                        state    <= WAIT_RISE;
                    end

                    WAIT_RISE: begin
                        if (rise) begin
                            high_cnt <= CNT_ONE;
                            low_cnt  <= '0;
                            state    <= MEAS_HIGH;
                        end
                    end

                    // A terminating edge takes priority over saturation in the same cycle.
                    MEAS_HIGH: begin
                        if (fall) begin
                            low_cnt <= CNT_ONE;
                            state   <= MEAS_LOW;
                        end else if (high_cnt == CNT_MAX) begin
                            stall_o  <= 1'b1;
                            high_cnt <= '0;
                            low_cnt  <= '0;
                            state    <= WAIT_RISE;
                        end else begin
                            high_cnt <= high_cnt + CNT_ONE;
                        end
                    end

                    MEAS_LOW: begin
                        if (rise) begin
                            high_o     <= high_cnt;
                            low_o      <= low_cnt;
                            period_o   <= {1'b0, high_cnt} + {1'b0, low_cnt};
                            valid_o    <= 1'b1;
                            meas_cnt_o <= meas_cnt_o + CNT_W'(1);
                            stall_o    <= 1'b0;
                            high_cnt   <= CNT_ONE;
                            low_cnt    <= '0;
                            state      <= MEAS_HIGH;
                        end else if (low_cnt == CNT_MAX) begin
                            stall_o  <= 1'b1;
                            high_cnt <= '0;
                            low_cnt  <= '0;
                            state    <= WAIT_RISE;
                        end else begin
                            low_cnt <= low_cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/iiitb_freqmeas.md
# iiitb_freqmeas

Clock-period and duty-cycle monitor that sits directly downstream of the programmable frequency divider. It samples the divider's `clkout` asynchronously in the `wb_clk_i` domain. For every complete output period it measures the high time and the low time in reference-clock cycles. Results go to management-visible registers (logic analyser / wishbone readback), so firmware can confirm the divide ratio and the 50 % duty behaviour for odd ratios.

## Interface
Parameters:
- `WIDTH`, default 16: width of the high/low counters and of the `high_o` / `low_o` result fields.
- `CNT_W`, default 8: width of the completed-measurement counter.

Ports:
- `wb_clk_i`  in  1: reference clock; all state is in this domain.
- `wb_rst_ni`  in  1: asynchronous, active-low reset.
- `en_i`  in  1: measurement enable, synchronous to `wb_clk_i`.
- `clk_div_i`  in  1: divider output. Asynchronous to `wb_clk_i`.
- `high_o`  out  WIDTH: high time of the last complete period, in cycles.
- `low_o`  out  WIDTH: low time of the last complete period, in cycles.
- `period_o`  out  WIDTH+1: `high_o + low_o`, with no truncation.
- `valid_o`  out  1: one-cycle pulse when the three result fields update.
- `stall_o`  out  1: sticky flag; no edge was seen before a counter saturated.
- `meas_cnt_o`  out  CNT_W: number of completed measurements, wrapping.

## Operation
- Input path:
  - Two-flop synchronizer `s1 -> s2`, then a history flop `s3`.
  - `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- State machine: `IDLE`, `WAIT_RISE`, `MEAS_HIGH`, `MEAS_LOW`.
- `IDLE`:
  - Counters are held at 0.
  - Moves to `WAIT_RISE` when `en_i = 1`.
- `WAIT_RISE`:
  - Discards the partial period seen at start-up.
  - On `rise`: `high_cnt <= 1`, `low_cnt <= 0`, go to `MEAS_HIGH`.
- `MEAS_HIGH`:
  - On `fall`: `low_cnt <= 1`, go to `MEAS_LOW`.
  - Otherwise `high_cnt <= high_cnt + 1`.
- `MEAS_LOW`:
  - On `rise`:
    - `high_o <= high_cnt`, `low_o <= low_cnt`, `period_o <= high_cnt + low_cnt` (WIDTH+1-bit add).
    - `valid_o <= 1`, `meas_cnt_o <= meas_cnt_o + 1` (wraps modulo 2^CNT_W).
    - `stall_o <= 0`.
    - `high_cnt <= 1`, `low_cnt <= 0`, go to `MEAS_HIGH`. Measurement is back-to-back, with no gap period.
  - Otherwise `low_cnt <= low_cnt + 1`.
- Saturation, in `MEAS_HIGH` or `MEAS_LOW`:
  - If the active counter equals `2^WIDTH - 1` and no terminating edge arrives in that cycle: `stall_o <= 1`, both counters clear, go to `WAIT_RISE`.
  - Result fields are not updated.
- `en_i = 0` in any state:
  - Next state is `IDLE`; counters and `stall_o` clear; `valid_o = 0`.
  - `high_o`, `low_o`, `period_o`, `meas_cnt_o` hold their last values.
- `en_i` and the synchronizer are independent. The synchronizer runs whenever the block is out of reset.

## Timing
- Reset (`wb_rst_ni = 0`, asynchronous):
  - State is `IDLE`.
  - `s1`, `s2`, `s3`, counters, `high_o`, `low_o`, `period_o`, `meas_cnt_o`, `valid_o`, `stall_o` are all 0.
- Deassertion of reset takes effect at the next `wb_clk_i` rising edge.
- Edge latency: an edge of `clk_div_i` sampled at rising edge k produces `rise`/`fall` asserted in the cycle after edge k+1.
- Latency is identical for both edges, so measured high/low counts equal the true durations in `wb_clk_i` cycles when `clk_div_i` is synchronous to `wb_clk_i`. Async jitter is ±1 count.
- `valid_o` is asserted for exactly one cycle, the cycle after the terminating `rise`. All result fields are stable from that cycle until the next `valid_o`.
- The first `valid_o` after enable arrives only after one discarded partial period plus one full period.
- Minimum measurable phase is 1 cycle high or low. Edges closer together than the synchronizer resolves are not detected, and those phases merge.
- Simultaneous saturation and terminating edge in the same cycle: the edge wins and the normal transition is taken.
- Reset mid-measurement abandons the measurement immediately. No `valid_o` is produced.

## Test plan
- **Basic measurement.** Drive `clk_div_i` synchronous to `wb_clk_i`, 3 cycles high / 5 cycles low, `en_i = 1`.
  - Every period: `valid_o` pulses with `high_o = 3`, `low_o = 5`, `period_o = 8`.
  - The first pulse comes only after the first full period; `meas_cnt_o` increments by 1 per pulse.
- **Odd-ratio duty.** 4 high / 3 low.
  - `high_o = 4`, `low_o = 3`, `period_o = 7`, repeated for 10 periods.
  - `meas_cnt_o = 10` after 10 pulses.
- **Stall.** `WIDTH = 4`, `clk_div_i` held at 1 after one rise.
  - `stall_o` rises once `high_cnt` reaches 15; FSM returns to `WAIT_RISE`; result fields are unchanged.
  - Restore toggling 2/2: `stall_o` clears on the next `valid_o`, which reports `high_o = 2`, `low_o = 2`.
- **Enable drop mid-period.**
  - Deassert `en_i` during `MEAS_LOW`: no `valid_o`, previous results held, `stall_o = 0`.
  - Reassert: one partial period is discarded, then correct results.
- **Async reset mid-measurement.**
  - Pulse `wb_rst_ni` low between clock edges: all outputs read 0 immediately.
  - Measurement restarts cleanly after release.
- **Counter wrap.** `CNT_W = 2`, 5 complete periods: `meas_cnt_o` sequence is 1, 2, 3, 0, 1.
